iter_muldiv: RTL and testbench
==============================

Name: iter_muldiv

Overview:
Iterative multiply/divide execution unit downstream of the 16x16 register file. It consumes the two read-port operands and a destination register ID, computes over multiple cycles, and produces a one-cycle write request (id, data, enable) for the register file write port. It shares the file's 4-bit register IDs and the rule that register 0 is never written.

Parameters:
WIDTH, 16, operand and result width in bits
ID_W, 4, register ID width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request a new operation; sampled only in IDLE
flush  input  1  synchronous abort; discards any in-flight operation
op  input  2  00 MULLO, 01 MULHI, 10 DIVU, 11 REMU (all unsigned)
src_a  input  WIDTH  multiplicand / dividend (register file read port 1)
src_b  input  WIDTH  multiplier / divisor (register file read port 2)
dst_id  input  ID_W  destination register
busy  output  1  high while in CALC or WB
done  output  1  one-cycle pulse in WB
wr_en  output  1  register file write enable; one-cycle pulse
wr_id  output  ID_W  register file destination ID
wr_data  output  WIDTH  register file write data
div_zero  output  1  valid with done; divisor was zero on DIVU/REMU

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - busy, done, wr_en, div_zero, wr_id, wr_data all 0.
  - Internal accumulators and counter cleared.
  - Reset mid-operation aborts with no write.
- FSM states: IDLE, CALC, WB.
- IDLE: when start=1 and flush=0 at edge k:
  - capture op, src_a, src_b, dst_id; counter=0.
  - Go to CALC.
  - Exception: DIVU/REMU with src_b=0 goes straight to WB.
- Operands are captured at start, so later changes on src_a, src_b and dst_id are ignored.
- CALC: one bit per cycle, WIDTH cycles (counter 0..WIDTH-1), then WB.
  - MUL uses shift-add into a 2*WIDTH product.
  - DIV/REM uses restoring division with a WIDTH+1-bit partial remainder.
- WB: lasts exactly one cycle, then IDLE.
  - done=1, wr_en=(wr_id!=0), wr_id=captured dst_id.
  - wr_data by op:
    - MULLO: product[WIDTH-1:0]
    - MULHI: product[2*WIDTH-1:WIDTH]
    - DIVU: quotient
    - REMU: remainder
  - div_zero=1 only for the zero-divisor case, which returns quotient all ones and remainder = src_a.
- Latency:
  - Normal operation: done at edge k+WIDTH+1, i.e. 17 cycles for WIDTH=16.
  - Zero divisor: done at edge k+1.
- Outside WB:
  - done and wr_en are 0.
  - wr_id and wr_data hold their last WB values.
  - div_zero is cleared when leaving WB.
- busy is 1 from edge k through the WB cycle inclusive.
- start is ignored while busy and is not queued. A start in the cycle after WB (IDLE) is accepted.
- flush=1 in any state:
  - next state IDLE, no WB, no write, busy falls next edge.
  - flush with start in IDLE: flush wins.
  - flush during WB does not suppress the current cycle's wr_en, which is already registered.
- All outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined:
  - MULLO/MULHI leave CALC after the cycle in which the remaining unshifted multiplier bits become zero.
  - CALC length = max(1, index of highest set bit of src_b + 1).
  - Division timing is unchanged.
- Undefined: every MUL takes exactly WIDTH CALC cycles.
- Results are identical either way.

Decomposition:
- Shared package (muldiv_pkg):
  - op encodings OP_MULLO, OP_MULHI, OP_DIVU, OP_REMU
  - state encodings for IDLE, CALC, WB
  - WIDTH and ID_W defaults
- One natural sub-module: muldiv_datapath, holding the product/remainder/quotient shift registers and adder/subtractor, stepped by the FSM's enable.
- The FSM and counter stay in iter_muldiv.

Test Plan:
- MULLO 0x1234 * 0x0010, dst_id=5, start at edge 0 -> busy edges 0-17; done=1, wr_en=1, wr_id=5, wr_data=0x2340 at edge 17 only.
- MULHI 0xFFFF * 0xFFFF, dst_id=3 -> wr_data=0xFFFE after 17 cycles; MULLO with the same operands -> 0x0001.
- DIVU 100/7 -> wr_data=14; REMU 100/7 -> wr_data=2; div_zero=0.
- DIVU 0x00AB/0, dst_id=2 -> done at edge 1 (1 cycle), wr_data=0xFFFF, div_zero=1; REMU 0x00AB/0 -> 0x00AB.
- MULLO 3*4 with dst_id=0 -> done=1, wr_en=0; start pulsed mid-CALC -> ignored, exactly one done.
- flush at CALC cycle 5 -> IDLE next edge, no done or wr_en. rst low at CALC cycle 8 -> outputs 0 immediately. With MULDIV_EARLY_EXIT_EN, MULLO 9*3 -> done at edge 3, wr_data=27.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings and default widths.
package muldiv_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int ID_W_DEF  = 4;

    // Operation select, all unsigned
    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    // Divide and remainder share the upper op bit
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift registers and adder/subtractor for the iterative multiply/divide unit.
// Multiply: the multiplicand shifts left and is accumulated into the product
// whenever the current multiplier LSB is set, so the product is final as soon
// as the remaining multiplier bits are zero.
// Divide: restoring division, one quotient bit per step.
// With MULDIV_EARLY_EXIT_EN defined an extra status output reports when the
// current step consumes the last set multiplier bit.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quo_o,
    output logic [WIDTH-1:0]   rem_o
`ifdef MULDIV_EARLY_EXIT_EN
    ,
    output logic               mul_rest_zero_o
`endif
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   div_q;

    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     shifted_d;
    logic [WIDTH-1:0]   diff_d;
    logic               fits_d;

    // Combinational step: conditional add for multiply, trial subtract for divide.
    // The remainder held between steps is always below the divisor, so only the
    // shifted partial remainder needs the extra bit; the low WIDTH bits of the
    // modular difference are exact whenever the subtraction fits.
    always_comb begin
        prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        shifted_d = {rem_q, quo_q[WIDTH-1]};
        fits_d    = (shifted_d >= {1'b0, div_q});
        diff_d    = shifted_d[WIDTH-1:0] - div_q;
    end

    // Operand load and per-cycle stepping of both engines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            prod_q   <= '0;
            mplier_q <= b_i;
            div_q    <= b_i;
            if (div_i && (b_i == '0)) begin
                // Divide by zero: no steps run, results are presented directly
                quo_q <= '1;
                rem_q <= a_i;
            end else begin
                quo_q <= a_i;
                rem_q <= '0;
            end
        end else if (step_i) begin
            prod_q   <= prod_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            if (fits_d) begin
                rem_q <= diff_d;
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted_d[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign prod_o = prod_q;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

`ifdef MULDIV_EARLY_EXIT_EN
    // High when the bit consumed this step is the last set multiplier bit
    assign mul_rest_zero_o = (mplier_q[WIDTH-1:1] == '0);
`endif

endmodule

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply/divide unit feeding a register file write port.
// Control FSM and step counter live here; arithmetic is in muldiv_datapath.
// A CALC pass runs the arithmetic steps and then spends one cycle registering
// the selected result, which is presented during the single WB cycle.
// Optional macro MULDIV_EARLY_EXIT_EN: multiplies end once no set multiplier
// bits remain; results are unchanged.
module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [ID_W-1:0]  dst_id,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [ID_W-1:0]  wr_id,
    output logic [WIDTH-1:0] wr_data,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q;
    op_e                op_q;
    logic [ID_W-1:0]    dst_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fin_q;
    logic               dz_q;
    logic               busy_q;
    logic               done_q;
    logic               wr_en_q;
    logic [ID_W-1:0]    wr_id_q;
    logic [WIDTH-1:0]   wr_data_q;
    logic               div_zero_q;

    logic               load_d;
    logic               step_d;
    logic               last_step_d;
    logic               b_zero_d;
    logic [WIDTH-1:0]   result_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
`ifdef MULDIV_EARLY_EXIT_EN
    logic               mul_rest_zero;
`endif

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_d),
        .step_i (step_d),
        .div_i  (op_is_div(op)),
        .a_i    (src_a),
        .b_i    (src_b),
        .prod_o (prod),
        .quo_o  (quo),
        .rem_o  (rem)
`ifdef MULDIV_EARLY_EXIT_EN
        ,
        .mul_rest_zero_o (mul_rest_zero)
`endif
    );

    // Datapath strobes, step termination and result selection
    always_comb begin
        b_zero_d = (src_b == '0);
        load_d   = (state_q == ST_IDLE) && start && !flush;
        step_d   = (state_q == ST_CALC) && !fin_q;
`ifdef MULDIV_EARLY_EXIT_EN
        last_step_d = (cnt_q == CNT_W'(WIDTH - 1)) ||
                      (!op_is_div(op_q) && mul_rest_zero);
`else
        last_step_d = (cnt_q == CNT_W'(WIDTH - 1));
`endif
        case (op_q)
            OP_MULLO: result_d = prod[WIDTH-1:0];
            OP_MULHI: result_d = prod[2*WIDTH-1:WIDTH];
            OP_DIVU:  result_d = quo;
            default:  result_d = rem;
        endcase
    end

    // Control FSM with registered outputs; flush overrides everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MULLO;
            dst_q      <= '0;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_id_q    <= '0;
            wr_data_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            if (flush) begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                div_zero_q <= 1'b0;
                fin_q      <= 1'b0;
                cnt_q      <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            op_q    <= op_e'(op);
                            dst_q   <= dst_id;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_CALC;
                            // A zero divisor skips all steps
                            fin_q   <= op_is_div(op) && b_zero_d;
                            dz_q    <= op_is_div(op) && b_zero_d;
                        end
                    end
                    ST_CALC: begin
                        if (fin_q) begin
                            state_q    <= ST_WB;
                            fin_q      <= 1'b0;
                            done_q     <= 1'b1;
                            wr_en_q    <= (dst_q != '0);
                            wr_id_q    <= dst_q;
                            wr_data_q  <= result_d;
                            div_zero_q <= dz_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (last_step_d) begin
                                fin_q <= 1'b1;
                            end
                        end
                    end
                    ST_WB: begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        div_zero_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_en    = wr_en_q;
    assign wr_id    = wr_id_q;
    assign wr_data  = wr_data_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_iter_muldiv;

    localparam int W = 16;

    typedef struct packed {
        logic [1:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  d;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] src_a = 16'd0;
    logic [15:0] src_b = 16'd0;
    logic [3:0]  dst_id = 4'd0;
    logic        busy, done, wr_en, div_zero;
    logic [3:0]  wr_id;
    logic [15:0] wr_data;

    int n_checks = 0;
    int n_fail = 0;

    iter_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .dst_id   (dst_id),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_id    (wr_id),
        .wr_data  (wr_data),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Reference result from plain arithmetic
    function automatic logic [15:0] model_result(input logic [1:0] o, input logic [15:0] a,
                                                 input logic [15:0] b);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        case (o)
            2'd0:    return p[15:0];
            2'd1:    return p[31:16];
            2'd2:    return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return (b == 16'd0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the start edge to the edge that raises done
    function automatic int model_latency(input logic [1:0] o, input logic [15:0] b);
        if (o[1] && b == 16'd0) return 1;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!o[1]) begin
            int n;
            n = 0;
            for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
            return ((n < 1) ? 1 : n) + 1;
        end
`endif
        return W + 1;
    endfunction

    // Drives one operation and records what the DUT showed (no checking here)
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] d, output int lat, output logic en,
                          output logic [3:0] id, output logic [15:0] data, output logic dz,
                          output logic busy_bad, output logic p_done, output logic p_en,
                          output logic p_busy, output logic p_dz, output logic [15:0] p_data);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; dst_id = d;
        @(posedge clk); #1;
        busy_bad = (busy !== 1'b1);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); src_a = 16'($urandom); src_b = 16'($urandom); dst_id = 4'($urandom);
        lat = -1; en = 1'b0; id = 4'd0; data = 16'd0; dz = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = c; en = wr_en; id = wr_id; data = wr_data; dz = div_zero;
                if (busy !== 1'b1) busy_bad = 1'b1;
                break;
            end
            if (busy !== 1'b1 || wr_en !== 1'b0) busy_bad = 1'b1;
        end
        @(posedge clk); #1;
        p_done = done; p_en = wr_en; p_busy = busy; p_dz = div_zero; p_data = wr_data;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        n_checks++; if (wr_id !== 4'd0) begin n_fail++; $display("FAIL reset_wr_id: got %h want 0", wr_id); end
        n_checks++; if (wr_data !== 16'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        @(negedge clk); rst = 1'b1;
        $display("reset released");
    endtask

    // Full per-operation comparison against the model, shared shape for table tests
    task automatic test_ops(input string name, input vec_t v[$]);
        int lat; logic en, dz, bb, pd, pe, pb, pz; logic [3:0] id; logic [15:0] data, pdata;
        logic [15:0] er; int el;
        foreach (v[i]) begin
            run_op(v[i].o, v[i].a, v[i].b, v[i].d, lat, en, id, data, dz, bb, pd, pe, pb, pz, pdata);
            er = model_result(v[i].o, v[i].a, v[i].b);
            el = model_latency(v[i].o, v[i].b);
            $display("%s[%0d] op=%0d a=%h b=%h dst=%0d -> lat=%0d data=%h en=%b dz=%b",
                     name, i, v[i].o, v[i].a, v[i].b, v[i].d, lat, data, en, dz);
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, el); end
            n_checks++; if (data !== er) begin n_fail++; $display("FAIL %s[%0d] wr_data: got %h want %h", name, i, data, er); end
            n_checks++; if (en !== (v[i].d != 4'd0)) begin n_fail++; $display("FAIL %s[%0d] wr_en: got %b want %b", name, i, en, v[i].d != 4'd0); end
            n_checks++; if (id !== v[i].d) begin n_fail++; $display("FAIL %s[%0d] wr_id: got %h want %h", name, i, id, v[i].d); end
            n_checks++; if (dz !== (v[i].o[1] && v[i].b == 16'd0)) begin n_fail++; $display("FAIL %s[%0d] div_zero: got %b want %b", name, i, dz, v[i].o[1] && v[i].b == 16'd0); end
            n_checks++; if (bb !== 1'b0) begin n_fail++; $display("FAIL %s[%0d] busy_window: got glitch=%b want 0", name, i, bb); end
            n_checks++; if ({pd, pe, pb, pz} !== 4'b0000) begin n_fail++; $display("FAIL %s[%0d] after_wb done/wr_en/busy/div_zero: got %b want 0000", name, i, {pd, pe, pb, pz}); end
            n_checks++; if (pdata !== er) begin n_fail++; $display("FAIL %s[%0d] wr_data_hold: got %h want %h", name, i, pdata, er); end
        end
    endtask

    task automatic test_mul();
        vec_t v[$];
        v.push_back('{2'd0, 16'h1234, 16'h0010, 4'd5});
        v.push_back('{2'd1, 16'hFFFF, 16'hFFFF, 4'd3});
        v.push_back('{2'd0, 16'hFFFF, 16'hFFFF, 4'd3});
        v.push_back('{2'd0, 16'h0009, 16'h0003, 4'd7});
        v.push_back('{2'd0, 16'h0003, 16'h0004, 4'd0});
        v.push_back('{2'd1, 16'h8001, 16'h0000, 4'd1});
        test_ops("mul", v);
    endtask

    task automatic test_div();
        vec_t v[$];
        v.push_back('{2'd2, 16'd100, 16'd7, 4'd4});
        v.push_back('{2'd3, 16'd100, 16'd7, 4'd6});
        v.push_back('{2'd2, 16'h00AB, 16'h0000, 4'd2});
        v.push_back('{2'd3, 16'h00AB, 16'h0000, 4'd2});
        v.push_back('{2'd2, 16'hFFFF, 16'h0001, 4'd8});
        v.push_back('{2'd3, 16'h1234, 16'hFFFF, 4'd9});
        test_ops("div", v);
    endtask

    task automatic test_start_ignored();
        int dones = 0; int first = -1; logic [15:0] d0 = 16'd0;
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_a = 16'h0101; src_b = 16'h0003; dst_id = 4'd9;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin start = 1'b1; op = 2'd2; src_a = 16'h7777; src_b = 16'h0005; end
            if (c == 6) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) begin first = c; d0 = wr_data; end
            end
            @(negedge clk);
        end
        $display("start_ignored: dones=%0d first=%0d data=%h", dones, first, d0);
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL start_ignored count: got %0d want 1", dones); end
        n_checks++; if (first != model_latency(2'd0, 16'h0003)) begin n_fail++; $display("FAIL start_ignored latency: got %0d want %0d", first, model_latency(2'd0, 16'h0003)); end
        n_checks++; if (d0 !== model_result(2'd0, 16'h0101, 16'h0003)) begin n_fail++; $display("FAIL start_ignored data: got %h want %h", d0, model_result(2'd0, 16'h0101, 16'h0003)); end
    endtask

    task automatic test_flush();
        int dones = 0; int wrs = 0;
        @(negedge clk);
        start = 1'b1; op = 2'd2; src_a = 16'd5000; src_b = 16'd3; dst_id = 4'd11;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc busy: got %b want 0", busy); end
        @(negedge clk); flush = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
            if (wr_en === 1'b1) wrs++;
        end
        n_checks++; if (dones != 0 || wrs != 0) begin n_fail++; $display("FAIL flush_calc outputs: got done=%0d wr_en=%0d want 0/0", dones, wrs); end
        // flush and start together in IDLE: flush wins
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 16'd2; src_b = 16'd2; dst_id = 4'd1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start busy: got %b want 0", busy); end
        @(negedge clk); start = 1'b0; flush = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL flush_start done: got %0d want 0", dones); end
        $display("flush scenarios complete");
    endtask

    task automatic test_async_reset();
        int lat; logic en, dz, bb, pd, pe, pb, pz; logic [3:0] id; logic [15:0] data, pdata;
        int dones = 0;
        run_op(2'd0, 16'h1234, 16'h0010, 4'd5, lat, en, id, data, dz, bb, pd, pe, pb, pz, pdata);
        n_checks++; if (pdata !== 16'h2340) begin n_fail++; $display("FAIL areset_pre data: got %h want 2340", pdata); end
        @(negedge clk);
        start = 1'b1; op = 2'd1; src_a = 16'hABCD; src_b = 16'h1234; dst_id = 4'd7;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset busy: got %b want 0", busy); end
        n_checks++; if (wr_data !== 16'd0) begin n_fail++; $display("FAIL areset wr_data: got %h want 0", wr_data); end
        n_checks++; if (wr_id !== 4'd0) begin n_fail++; $display("FAIL areset wr_id: got %h want 0", wr_id); end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || wr_en === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL areset no_write: got %0d want 0", dones); end
        $display("async reset scenario complete");
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back('{2'd3, 16'd65535, 16'd10, 4'd12});
        v.push_back('{2'd0, 16'd300, 16'd200, 4'd13});
        v.push_back('{2'd2, 16'd7, 16'd0, 4'd14});
        v.push_back('{2'd1, 16'h4000, 16'h0004, 4'd15});
        test_ops("b2b", v);
    endtask

    task automatic test_random();
        vec_t v[$];
        vec_t t;
        for (int i = 0; i < 40; i++) begin
            t.o = 2'($urandom);
            t.a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: t.b = 16'd0;
                1: t.b = 16'($urandom_range(1, 255));
                default: t.b = 16'($urandom);
            endcase
            t.d = 4'($urandom);
            v.push_back(t);
        end
        test_ops("rand", v);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_start_ignored();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
